mux_sel_sequencer: RTL and testbench
====================================

Name: mux_sel_sequencer

Overview:
- Upstream control stage for the 8:1 data-routing mux.
- Accepts one 8-bit word over a valid/ready handshake and holds it on `word_out`, which drives the mux data input.
- Steps `sel` through all eight indices, one per accepted beat, so the mux output emits the word serially.
- Supports LSB-first or MSB-first order, downstream backpressure, and back-to-back words with no idle cycle.

Parameters:
- WIDTH, 8, data word width (number of mux inputs).
- SEL_W, 3, select width; must equal clog2(WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  word to serialize.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts a word this cycle.
- msb_first  input  1  order for the word being loaded: 1 = index 7 down to 0, 0 = index 0 up to 7.
- word_out  output  WIDTH  registered word, to mux `in`.
- sel  output  SEL_W  registered select, to mux `sel`.
- bit_valid  output  1  current mux output (`word_out[sel]`) is a valid beat.
- out_ready  input  1  downstream consumes the beat this cycle.
- first_bit  output  1  current beat is index 0 of the sequence.
- last_bit  output  1  current beat is index WIDTH-1 of the sequence.
- busy  output  1  state is SEND.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous, active-high.
- Reset values: state IDLE, word_out 0, sel 0, bit_valid 0, first_bit 0, last_bit 0, busy 0, internal beat count 0, internal order flag 0.
- IDLE state:
  - in_ready = 1.
  - On in_valid && in_ready: word_out <= in_data; order flag <= msb_first; sel <= msb_first ? WIDTH-1 : 0; count <= 0; next state SEND.
- SEND state:
  - bit_valid = 1, busy = 1.
  - A beat is accepted when bit_valid && out_ready.
  - On an accepted beat with count < WIDTH-1: count++; sel += 1 (LSB-first) or sel -= 1 (MSB-first).
  - Without out_ready: sel, count and word_out hold (stall of any length).
- Last beat (count == WIDTH-1):
  - in_ready = out_ready (combinational path from out_ready to in_ready).
  - Accepted beat with in_valid = 1: reload exactly as in IDLE and stay in SEND. No bubble; the next word's first beat is presented the following cycle.
  - Accepted beat with in_valid = 0: go to IDLE; sel holds its last value.
- Flags:
  - first_bit = SEND && count == 0.
  - last_bit = SEND && count == WIDTH-1.
  - Both are combinational from registered state.
- Latency: word accepted in cycle N; first beat valid in cycle N+1; with out_ready held high, the last beat is in cycle N+WIDTH.
- Ordering rules:
  - msb_first is sampled only at load; changes mid-word are ignored.
  - in_data is ignored except at load.
- sel never wraps within a word. The count bounds the sequence; sel arithmetic is modulo 2^SEL_W.
- Reset mid-word: abandon the word immediately and return to the reset values above. The next word then starts from index 0 or WIDTH-1 as normal.
- No beat is lost or duplicated under any pattern of out_ready.

Decomposition:
- Shared package `mux_pkg`:
  - WIDTH and SEL_W defaults.
  - State enum {IDLE, SEND}.
  - localparams LAST_IDX = WIDTH-1 and SEL_MSB_START = WIDTH-1.
- One natural sub-module, `updown_sel_counter`: load value, enable, direction, SEL_W-bit registered output.
- Top level holds the FSM, the word register and the handshake logic.
- Bench instantiates mux_sel_sequencer feeding mux_8x1 (`.in(word_out)`, `.sel(sel)`) and checks `y`.

Test Plan:
1. Reset, then in_data=8'hAA, msb_first=0, out_ready=1 -> sel 0..7 on 8 consecutive cycles, y = 0,1,0,1,0,1,0,1; first_bit on beat 0, last_bit on beat 7, then IDLE with in_ready=1.
2. in_data=8'hB4, msb_first=1 -> sel 7..0, y = 1,0,1,1,0,1,0,0.
3. 8'hAA then 8'h0F presented back-to-back with in_valid held -> 16 contiguous beats with no gap; y = 0,1,0,1,0,1,0,1 then 1,1,1,1,0,0,0,0; in_ready pulses only on the last beat of word 1.
4. Word 8'h5A with out_ready toggling 1,0,0,1,... -> sel and y hold while out_ready=0; the sequence of accepted beats equals the bits of 8'h5A LSB-first (0,1,0,1,1,0,1,0).
5. rst asserted for one cycle at beat 3 of 8'hFF -> next cycle busy=0, sel=0, bit_valid=0; then load 8'h01 -> y = 1,0,0,0,0,0,0,0.
6. msb_first toggled mid-word and in_data changed while busy -> output order and bits unchanged for the current word.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the mux select sequencer: default sizes, state encoding
// and the start indices of the serial sequence.
package mux_pkg;
  localparam int DEF_WIDTH     = 8;
  localparam int DEF_SEL_W     = 3;
  localparam int LAST_IDX      = DEF_WIDTH - 1;
  localparam int SEL_MSB_START = DEF_WIDTH - 1;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;
endpackage

// File: rtl/mux_8x1.sv
// Data-routing mux driven by the sequencer: y = in[sel].
module mux_8x1 #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3
) (
  input  logic [WIDTH-1:0] in,
  input  logic [SEL_W-1:0] sel,
  output logic             y
);
  assign y = in[sel];
endmodule

// File: rtl/updown_sel_counter.sv
// Loadable up/down select counter; wraps modulo 2^SEL_W, the caller bounds the run.
module updown_sel_counter #(
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [SEL_W-1:0] i_load_val,
  input  logic             i_en,
  input  logic             i_dn,
  output logic [SEL_W-1:0] o_q
);
  logic [SEL_W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst)         r_q <= '0;
    else if (i_load) r_q <= i_load_val;
    else if (i_en)   r_q <= i_dn ? r_q - 1'b1 : r_q + 1'b1;
  end

  assign o_q = r_q;
endmodule

// File: rtl/mux_sel_sequencer.sv
// Holds one accepted word on word_out and walks sel across every index, one beat
// per downstream accept, with back-to-back reload on the final beat.
module mux_sel_sequencer
  import mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEL_W = DEF_SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             msb_first,
  output logic [WIDTH-1:0] word_out,
  output logic [SEL_W-1:0] sel,
  output logic             bit_valid,
  input  logic             out_ready,
  output logic             first_bit,
  output logic             last_bit,
  output logic             busy
);
  localparam logic [SEL_W-1:0] LastCnt  = SEL_W'(WIDTH - 1);
  localparam logic [SEL_W-1:0] MsbStart = SEL_W'(WIDTH - 1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_word;
  logic [SEL_W-1:0] r_cnt;
  logic             r_msb;
  logic             w_send, w_last, w_load, w_beat, w_step;

  assign w_send = (r_state == SEND);
  assign w_last = w_send && (r_cnt == LastCnt);
  assign w_beat = w_send && out_ready;
  assign w_step = w_beat && !w_last;
  assign w_load = in_valid && in_ready;

  // in_ready follows out_ready combinationally on the last beat so the next word
  // can be taken in the same cycle the final bit leaves.
  always_comb begin
    in_ready    = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = SEND;
      end
      SEND: begin
        if (w_last) begin
          in_ready = out_ready;
          if (out_ready && !in_valid) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_word  <= '0;
      r_cnt   <= '0;
      r_msb   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_word <= in_data;
        r_msb  <= msb_first;
        r_cnt  <= '0;
      end else if (w_step) begin
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

  updown_sel_counter #(.SEL_W(SEL_W)) u_sel (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (msb_first ? MsbStart : '0),
    .i_en       (w_step),
    .i_dn       (r_msb),
    .o_q        (sel)
  );

  assign word_out  = r_word;
  assign bit_valid = w_send;
  assign busy      = w_send;
  assign first_bit = w_send && (r_cnt == '0);
  assign last_bit  = w_last;
endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Scoreboard bench: drivers push expected beats, a negedge monitor pops and
// compares each beat the downstream accepts at the mux output.
module tb_mux_sel_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       msb_first = 1'b0;
  logic [7:0] word_out;
  logic [2:0] sel;
  logic       bit_valid;
  logic       out_ready = 1'b1;
  logic       first_bit, last_bit, busy;
  logic       y;

  typedef struct packed {
    logic [2:0] sel;
    logic       y;
    logic       first;
    logic       last;
  } beat_t;

  beat_t q_exp[$];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mux_sel_sequencer dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .msb_first(msb_first), .word_out(word_out),
    .sel(sel), .bit_valid(bit_valid), .out_ready(out_ready),
    .first_bit(first_bit), .last_bit(last_bit), .busy(busy)
  );

  mux_8x1 u_mux (.in(word_out), .sel(sel), .y(y));

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected beats are hand-derived from the word: index order, bit, flags.
  task automatic push_word(input logic [7:0] data, input logic msb);
    for (int k = 0; k < 8; k++) begin
      beat_t b;
      b.sel   = msb ? 3'(7 - k) : 3'(k);
      b.y     = data[b.sel];
      b.first = (k == 0);
      b.last  = (k == 7);
      q_exp.push_back(b);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bit_valid && out_ready) begin
      if (q_exp.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL beat_unexpected: got sel=%0d y=%0d expected no beat", sel, y);
      end else begin
        beat_t e;
        e = q_exp.pop_front();
        chk("beat_sel",   int'(sel),       int'(e.sel));
        chk("beat_y",     int'(y),         int'(e.y));
        chk("beat_first", int'(first_bit), int'(e.first));
        chk("beat_last",  int'(last_bit),  int'(e.last));
      end
    end
  end

  // Presents a word and holds in_valid until a handshake; returns at posedge+1.
  task automatic send_word(input logic [7:0] data, input logic msb);
    bit ok = 0;
    @(posedge clk); #1;
    in_data = data; msb_first = msb; in_valid = 1'b1;
    push_word(data, msb);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("load_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (q_exp.size() == 0 && !busy) begin ok = 1; break; end
    end
    chk(name, int'(ok), 1);
  endtask

  initial begin
    logic [3:0] pat;
    logic       prev_or;
    logic [2:0] prev_sel;
    logic       prev_y;
    int         cyc;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy",      int'(busy),      0);
    chk("rst_bit_valid", int'(bit_valid), 0);
    chk("rst_sel",       int'(sel),       0);
    chk("rst_word_out",  int'(word_out),  0);
    chk("rst_in_ready",  int'(in_ready),  1);
    chk("rst_first",     int'(first_bit), 0);
    chk("rst_last",      int'(last_bit),  0);

    // 1: LSB-first 0xAA
    send_word(8'hAA, 1'b0);
    wait_idle("t1_done");
    chk("t1_in_ready_idle", int'(in_ready), 1);

    // 2: MSB-first 0xB4
    send_word(8'hB4, 1'b1);
    wait_idle("t2_done");

    // 3: back-to-back 0xAA then 0x0F, no gap, in_ready only on word-1 last beat
    send_word(8'hAA, 1'b0);
    in_valid = 1'b1; in_data = 8'h0F; msb_first = 1'b0;
    push_word(8'h0F, 1'b0);
    // send_word already dropped in_valid after the first accept; restore it here
    // before the first beat's negedge so only the last beat can take word 2.
    for (int i = 2; i <= 16; i++) begin
      @(negedge clk);
      chk("t3_contig_valid", int'(bit_valid), 1);
      if (i <= 15) chk("t3_in_ready", int'(in_ready), (i == 9) ? 1 : 0);
      if (i == 9) begin @(posedge clk); #1 in_valid = 1'b0; end
    end
    wait_idle("t3_done");

    // 4: 0x5A with out_ready pattern 1,0,0,1,...
    pat = 4'b1001;
    send_word(8'h5A, 1'b0);
    prev_or = 1'b1; prev_sel = '0; prev_y = 1'b0; cyc = 0;
    while (q_exp.size() != 0 && cyc < 100) begin
      out_ready = pat[cyc % 4];
      @(negedge clk);
      if (!prev_or) begin
        chk("t4_stall_sel", int'(sel), int'(prev_sel));
        chk("t4_stall_y",   int'(y),   int'(prev_y));
      end
      prev_or = out_ready; prev_sel = sel; prev_y = y;
      @(posedge clk); #1;
      cyc++;
    end
    chk("t4_drained", int'(q_exp.size()), 0);
    out_ready = 1'b1;
    wait_idle("t4_done");

    // 5: reset during beat 3 of 0xFF, then 0x01
    send_word(8'hFF, 1'b0);
    q_exp.delete();
    for (int k = 0; k < 3; k++) begin
      beat_t b;
      b.sel = 3'(k); b.y = 1'b1; b.first = (k == 0); b.last = 1'b0;
      q_exp.push_back(b);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("t5_beat3_sel", int'(sel), 3);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_busy",      int'(busy),      0);
    chk("t5_rst_sel",       int'(sel),       0);
    chk("t5_rst_bit_valid", int'(bit_valid), 0);
    chk("t5_rst_q_empty",   int'(q_exp.size()), 0);
    send_word(8'h01, 1'b0);
    wait_idle("t5_done");

    // 6: msb_first and in_data changed mid-word are ignored
    send_word(8'hC3, 1'b0);
    repeat (2) @(posedge clk);
    #1 msb_first = 1'b1; in_data = 8'h00;
    wait_idle("t6_done");
    chk("t6_word_hold", int'(word_out), 8'hC3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
